// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared types and constants for the two-master on-chip memory arbiter.
package onchip_mem_arbiter_pkg;

  // Default geometry of the memory port.
  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEFAULT_DATA_W = 32;

  // Legal range of the memory read latency, in clock cycles.
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Identifies which master owns a transfer.
  typedef enum logic {
    MASTER_0 = 1'b0,
    MASTER_1 = 1'b1
  } master_id_e;

  // Arbiter phase: HOLD covers reset and the single cycle after release.
  typedef enum logic {
    PH_HOLD = 1'b0,
    PH_RUN  = 1'b1
  } phase_e;

  // The master that did not win last time; used to break ties.
  function automatic master_id_e other_master(input master_id_e m);
    return (m == MASTER_0) ? MASTER_1 : MASTER_0;
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-tag shift register: follows each granted read through the memory
// latency so the returning data can be steered to its owner.
module rd_tag_pipe
  import onchip_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_valid_i,
  input  master_id_e push_id_i,
  output logic       pop_valid_o,
  output master_id_e pop_id_o
);

  logic [DEPTH-1:0] valid_q, valid_d;
  master_id_e       id_q [DEPTH];
  master_id_e       id_d [DEPTH];

  // Next stage contents: new tag into stage 0, everything else shifts down.
  always_comb begin
    valid_d    = valid_q;
    id_d       = id_q;
    valid_d[0] = push_valid_i;
    id_d[0]    = push_id_i;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      id_d[i]    = id_q[i-1];
    end
  end

  // Tag registers; reset drops every read still in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      id_q    <= '{default: MASTER_0};
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

  assign pop_valid_o = valid_q[DEPTH-1];
  assign pop_id_o    = id_q[DEPTH-1];

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter that lets two masters share one on-chip memory port.
// Handshake: a master holds read/write with stable address/data until it
// sees waitrequest low in the same cycle; that cycle completes the transfer.
// Read data comes back RD_LAT cycles later, qualified by readdatavalid.
module onchip_mem_arbiter
  import onchip_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_clken,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                mem_reset_req
);

  // Out-of-range latencies are pinned to the nearest legal depth.
  localparam int TAG_DEPTH = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX :
                             (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN : RD_LAT;

  phase_e     phase_q, phase_d;
  master_id_e last_grant_q, last_grant_d;
  logic       run;
  logic       req0, req1;
  logic       gnt0, gnt1;
  logic       rd_push;
  master_id_e push_id;
  logic       pop_valid;
  master_id_e pop_id;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Phase register: reset parks the arbiter in HOLD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase_q <= PH_HOLD;
    else       phase_q <= phase_d;
  end

  // Next phase: HOLD lasts exactly one cycle past reset release.
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_HOLD: phase_d = PH_RUN;
      default: phase_d = PH_RUN;
    endcase
  end

  // Phase outputs: grants only in RUN, memory reset request during HOLD.
  always_comb begin
    run           = (phase_q == PH_RUN);
    mem_reset_req = (phase_q == PH_HOLD);
  end

  // Grant: a sole requester wins; a tie goes to the master not served last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (run) begin
      if (req0 && req1) begin
        gnt0 = (other_master(last_grant_q) == MASTER_0);
        gnt1 = ~gnt0;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Remember the winner; idle cycles leave the history untouched.
  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt0)      last_grant_d = MASTER_0;
    else if (gnt1) last_grant_d = MASTER_1;
  end

  // Round-robin history; reset favours m0 on the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_grant_q <= MASTER_1;
    else       last_grant_q <= last_grant_d;
  end

  // Memory command mux: the granted master drives the port, idle is all-zero.
  always_comb begin
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_writedata  = '0;
    mem_byteenable = '0;
    if (gnt0) begin
      mem_chipselect = 1'b1;
      mem_write      = m0_write;
      mem_address    = m0_address;
      mem_writedata  = m0_writedata;
      mem_byteenable = m0_byteenable;
    end else if (gnt1) begin
      mem_chipselect = 1'b1;
      mem_write      = m1_write;
      mem_address    = m1_address;
      mem_writedata  = m1_writedata;
      mem_byteenable = m1_byteenable;
    end
  end

  // Read+write together counts as a write, so only pure reads are tagged.
  assign rd_push = mem_chipselect & ~mem_write;
  assign push_id = gnt1 ? MASTER_1 : MASTER_0;

  rd_tag_pipe #(
    .DEPTH(TAG_DEPTH)
  ) u_rd_tag_pipe (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_valid_i(rd_push),
    .push_id_i   (push_id),
    .pop_valid_o (pop_valid),
    .pop_id_o    (pop_id)
  );

  assign mem_clken        = ~reset;
  assign m0_waitrequest   = ~run | (req0 & ~gnt0);
  assign m1_waitrequest   = ~run | (req1 & ~gnt1);
  assign m0_readdatavalid = pop_valid & (pop_id == MASTER_0);
  assign m1_readdatavalid = pop_valid & (pop_id == MASTER_1);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a 2-cycle-latency memory model.
module tb_onchip_mem_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;

  logic        clk;
  logic        reset;
  logic [7:0]  m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [7:0]  mem_address;
  logic        mem_clken, mem_chipselect, mem_write, mem_reset_req;
  logic [31:0] mem_writedata, mem_readdata;
  logic [3:0]  mem_byteenable;

  int n_checks;
  int n_pass;

  onchip_mem_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .m0_address      (m0_address),
    .m0_read         (m0_read),
    .m0_write        (m0_write),
    .m0_writedata    (m0_writedata),
    .m0_byteenable   (m0_byteenable),
    .m0_waitrequest  (m0_waitrequest),
    .m0_readdata     (m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address      (m1_address),
    .m1_read         (m1_read),
    .m1_write        (m1_write),
    .m1_writedata    (m1_writedata),
    .m1_byteenable   (m1_byteenable),
    .m1_waitrequest  (m1_waitrequest),
    .m1_readdata     (m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address     (mem_address),
    .mem_clken       (mem_clken),
    .mem_chipselect  (mem_chipselect),
    .mem_write       (mem_write),
    .mem_writedata   (mem_writedata),
    .mem_byteenable  (mem_byteenable),
    .mem_readdata    (mem_readdata),
    .mem_reset_req   (mem_reset_req)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: byte-lane writes, two-register read path (RD_LAT = 2).
  logic [31:0] mem_arr [256];
  logic [31:0] rd0, rd1;
  always @(posedge clk) begin
    if (mem_chipselect && mem_write) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_byteenable[b]) mem_arr[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end
    end
    rd0 <= mem_arr[mem_address];
    rd1 <= rd0;
  end
  assign mem_readdata = rd1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle_all();
    m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_writedata = '0; m0_byteenable = '0;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_writedata = '0; m1_byteenable = '0;
  endtask

  task automatic drive(input int m, input logic rd, input logic wr, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    end
  endtask

  // Inputs change just after a rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int i0, i1, k;
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    idle_all();

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_wait0",   32'(m0_waitrequest), 32'(1));
    check("rst_wait1",   32'(m1_waitrequest), 32'(1));
    check("rst_cs",      32'(mem_chipselect), 32'(0));
    check("rst_wr",      32'(mem_write), 32'(0));
    check("rst_clken",   32'(mem_clken), 32'(0));
    check("rst_rdv0",    32'(m0_readdatavalid), 32'(0));
    check("rst_rdv1",    32'(m1_readdatavalid), 32'(0));
    check("rst_rstreq",  32'(mem_reset_req), 32'(1));
    next_cycle();
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, 8'h10, 32'h0, 4'hF);
    @(negedge clk);
    check("hold_rstreq", 32'(mem_reset_req), 32'(1));
    check("hold_wait0",  32'(m0_waitrequest), 32'(1));
    check("hold_cs",     32'(mem_chipselect), 32'(0));
    check("hold_clken",  32'(mem_clken), 32'(1));
    next_cycle();
    idle_all();
    @(negedge clk);
    check("run_rstreq",  32'(mem_reset_req), 32'(0));
    check("run_wait0",   32'(m0_waitrequest), 32'(0));
    check("idle_addr",   32'(mem_address), 32'(0));
    next_cycle();

    // ---- single master write then read ----
    drive(0, 1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    check("sm_wr_wait",  32'(m0_waitrequest), 32'(0));
    check("sm_wr_cs",    32'(mem_chipselect), 32'(1));
    check("sm_wr_we",    32'(mem_write), 32'(1));
    check("sm_wr_addr",  32'(mem_address), 32'h10);
    check("sm_wr_data",  mem_writedata, 32'hDEADBEEF);
    check("sm_wr_be",    32'(mem_byteenable), 32'hF);
    next_cycle();
    drive(0, 1'b1, 1'b0, 8'h10, 32'h0, 4'hF);
    @(negedge clk);
    check("sm_rd_wait",  32'(m0_waitrequest), 32'(0));
    check("sm_rd_we",    32'(mem_write), 32'(0));
    next_cycle();
    idle_all();
    @(negedge clk);
    check("sm_lat1_rdv0", 32'(m0_readdatavalid), 32'(0));
    check("sm_idle_cs",   32'(mem_chipselect), 32'(0));
    next_cycle();
    @(negedge clk);
    check("sm_rdv0",     32'(m0_readdatavalid), 32'(1));
    check("sm_rdata",    m0_readdata, 32'hDEADBEEF);
    check("sm_rdv1",     32'(m1_readdatavalid), 32'(0));
    next_cycle();
    @(negedge clk);
    check("sm_rdv0_end", 32'(m0_readdatavalid), 32'(0));
    next_cycle();

    // ---- preload by m1 (leaves last grant on m1) ----
    for (int j = 0; j < 8; j++) begin
      drive(1, 1'b0, 1'b1, 8'(8'h20 + j), 32'hC0DE0000 + 32'(j), 4'hF);
      @(negedge clk);
      check("pre_wait1", 32'(m1_waitrequest), 32'(0));
      next_cycle();
    end
    idle_all();

    // ---- contention: both masters read for 8 cycles ----
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 10; c++) begin
      idle_all();
      if (c < 8) begin
        drive(0, 1'b1, 1'b0, 8'(8'h20 + i0), 32'h0, 4'hF);
        drive(1, 1'b1, 1'b0, 8'(8'h24 + i1), 32'h0, 4'hF);
      end
      @(negedge clk);
      if (c < 8) begin
        check("rr_wait0", 32'(m0_waitrequest), 32'((c % 2) != 0));
        check("rr_wait1", 32'(m1_waitrequest), 32'((c % 2) == 0));
        check("rr_addr",  32'(mem_address), (c % 2 == 0) ? 32'(8'h20 + i0) : 32'(8'h24 + i1));
      end
      if (c >= 2) begin
        k = (c - 2) / 2;
        if ((c - 2) % 2 == 0) begin
          check("rr_rdv0_on",  32'(m0_readdatavalid), 32'(1));
          check("rr_rdv1_off", 32'(m1_readdatavalid), 32'(0));
          check("rr_data0",    m0_readdata, 32'hC0DE0000 + 32'(k));
        end else begin
          check("rr_rdv1_on",  32'(m1_readdatavalid), 32'(1));
          check("rr_rdv0_off", 32'(m0_readdatavalid), 32'(0));
          check("rr_data1",    m1_readdata, 32'hC0DE0004 + 32'(k));
        end
      end else begin
        check("rr_early_rdv0", 32'(m0_readdatavalid), 32'(0));
        check("rr_early_rdv1", 32'(m1_readdatavalid), 32'(0));
      end
      if (c < 8) begin
        if (c % 2 == 0) i0++;
        else            i1++;
      end
      next_cycle();
    end
    idle_all();

    // ---- byte lanes, plus a write accepted during a read return ----
    drive(0, 1'b0, 1'b1, 8'h05, 32'h11223344, 4'hF);
    next_cycle();
    idle_all();
    drive(1, 1'b0, 1'b1, 8'h05, 32'h000000AA, 4'h1);
    @(negedge clk);
    check("bl_be", 32'(mem_byteenable), 32'h1);
    next_cycle();
    idle_all();
    drive(1, 1'b1, 1'b0, 8'h05, 32'h0, 4'hF);
    next_cycle();
    idle_all();
    @(negedge clk);
    check("bl_lat1_rdv1", 32'(m1_readdatavalid), 32'(0));
    next_cycle();
    drive(0, 1'b0, 1'b1, 8'h30, 32'h5555AAAA, 4'hF);
    @(negedge clk);
    check("bl_rdv1",      32'(m1_readdatavalid), 32'(1));
    check("bl_data",      m1_readdata, 32'h112233AA);
    check("bl_rdv0",      32'(m0_readdatavalid), 32'(0));
    check("rw_ov_wait0",  32'(m0_waitrequest), 32'(0));
    check("rw_ov_we",     32'(mem_write), 32'(1));
    check("rw_ov_addr",   32'(mem_address), 32'h30);
    next_cycle();
    idle_all();

    // ---- read and write together count as a write ----
    drive(1, 1'b1, 1'b1, 8'hFF, 32'h0BADF00D, 4'hF);
    @(negedge clk);
    check("rw_wait1", 32'(m1_waitrequest), 32'(0));
    check("rw_we",    32'(mem_write), 32'(1));
    check("rw_addr",  32'(mem_address), 32'hFF);
    check("rw_data",  mem_writedata, 32'h0BADF00D);
    next_cycle();
    idle_all();
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("rw_no_rdv1", 32'(m1_readdatavalid), 32'(0));
      next_cycle();
    end
    drive(1, 1'b1, 1'b0, 8'hFF, 32'h0, 4'hF);
    next_cycle();
    idle_all();
    next_cycle();
    @(negedge clk);
    check("rw_rb_rdv1", 32'(m1_readdatavalid), 32'(1));
    check("rw_rb_data", m1_readdata, 32'h0BADF00D);
    next_cycle();

    // ---- reset with two reads in flight ----
    drive(0, 1'b1, 1'b0, 8'h20, 32'h0, 4'hF);
    next_cycle();
    drive(0, 1'b1, 1'b0, 8'h21, 32'h0, 4'hF);
    next_cycle();
    reset = 1'b1;
    idle_all();
    drive(0, 1'b1, 1'b0, 8'h20, 32'h0, 4'hF);
    drive(1, 1'b1, 1'b0, 8'h24, 32'h0, 4'hF);
    @(negedge clk);
    check("mf_rdv0",   32'(m0_readdatavalid), 32'(0));
    check("mf_rdv1",   32'(m1_readdatavalid), 32'(0));
    check("mf_wait0",  32'(m0_waitrequest), 32'(1));
    check("mf_wait1",  32'(m1_waitrequest), 32'(1));
    check("mf_rstreq", 32'(mem_reset_req), 32'(1));
    check("mf_clken",  32'(mem_clken), 32'(0));
    check("mf_cs",     32'(mem_chipselect), 32'(0));
    next_cycle();
    @(negedge clk);
    check("mf_rdv0_b", 32'(m0_readdatavalid), 32'(0));
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("mf_hold_rstreq", 32'(mem_reset_req), 32'(1));
    check("mf_hold_wait0",  32'(m0_waitrequest), 32'(1));
    check("mf_hold_wait1",  32'(m1_waitrequest), 32'(1));
    check("mf_hold_cs",     32'(mem_chipselect), 32'(0));
    check("mf_hold_rdv0",   32'(m0_readdatavalid), 32'(0));
    next_cycle();
    @(negedge clk);
    check("mf_run_rstreq", 32'(mem_reset_req), 32'(0));
    check("mf_tie_wait0",  32'(m0_waitrequest), 32'(0));
    check("mf_tie_wait1",  32'(m1_waitrequest), 32'(1));
    check("mf_tie_addr",   32'(mem_address), 32'h20);
    next_cycle();
    idle_all();
    @(negedge clk);
    check("mf_post_rdv0", 32'(m0_readdatavalid), 32'(0));
    check("mf_post_rdv1", 32'(m1_readdatavalid), 32'(0));
    next_cycle();
    @(negedge clk);
    check("mf_new_rdv0", 32'(m0_readdatavalid), 32'(1));
    check("mf_new_data", m0_readdata, 32'hC0DE0000);
    check("mf_new_rdv1", 32'(m1_readdatavalid), 32'(0));
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
